// File: rtl/pll_rst_pkg.sv
// Shared types for the PLL lock supervisor / reset sequencer.
package pll_rst_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    WAIT_LOCK = 3'd0,
    RELOCK    = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for a single asynchronous level; synchronous reset to 0.
module pll_lock_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock supervisor: waits for stable lock, releases staggered resets, requests relock.
// Optional saturating lock-loss counter built only when PLL_RST_LOSS_CNT_EN is defined.
module pll_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned NUM_RST        = 3,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned STAGGER        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned RELOCK_PULSE   = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               pll_locked,
  output logic               pll_relock,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic [ST_W-1:0]    state,
  output logic [CNT_W-1:0]   loss_count
);

  // One shared phase counter, sized for the longest phase it has to time.
  localparam int unsigned REL_LEN = (NUM_RST - 1) * STAGGER + 1;
  localparam int unsigned CNT_MAX = max_u(max_u(TIMEOUT_CYCLES, STABLE_CYCLES),
                                          max_u(RELOCK_PULSE, REL_LEN));
  localparam int unsigned TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] RP_LAST  = TW'(RELOCK_PULSE - 1);
  localparam logic [TW-1:0] ST_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] REL_LAST = TW'(REL_LEN - 1);

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .clk   (clock_in),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  state_t             state_q, state_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic [NUM_RST-1:0] rst_q, rst_d;
  logic               ready_q, ready_d;
  logic               relock_q, relock_d;
  logic               lock_lost;

  assign lock_lost = ((state_q == RELEASE) || (state_q == RUN)) && !lock_s;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      cnt_q    <= '0;
      rst_q    <= '1;
      ready_q  <= 1'b0;
      relock_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rst_q    <= rst_d;
      ready_q  <= ready_d;
      relock_q <= relock_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + TW'(1);
    rst_d    = rst_q;
    ready_d  = ready_q;
    relock_d = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d  = RELOCK;
          cnt_d    = '0;
          relock_d = 1'b1;
        end
      end
      RELOCK: begin
        relock_d = 1'b1;
        if (cnt_q == RP_LAST) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          relock_d = 1'b0;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == ST_LAST) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        // Bit i drops the cycle after k == i*STAGGER; earlier bits stay released.
        for (int unsigned i = 0; i < NUM_RST; i++) begin
          if (cnt_q == TW'(i * STAGGER)) rst_d[i] = 1'b0;
        end
        if (cnt_q == REL_LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
        rst_d   = '1;
        ready_d = 1'b0;
      end
    endcase
    if (lock_lost) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
    end
  end

  assign state      = state_q;
  assign rst_out    = rst_q;
  assign ready      = ready_q;
  assign pll_relock = relock_q;

`ifdef PLL_RST_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_q;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      loss_q <= '0;
    end else if (lock_lost && (loss_q != '1)) begin
      loss_q <= loss_q + CNT_W'(1);
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Randomised scoreboard bench for pll_reset_seq against a phase/elapsed-time model.
module tb_pll_reset_seq;

  localparam int N     = 3;
  localparam int SC    = 8;
  localparam int S     = 4;
  localparam int T     = 32;
  localparam int P     = 4;
  localparam int PER   = T + P;
  localparam int LASTK = (N - 1) * S;
  localparam int LCMAX = 3;

  localparam int P_WAIT = 0;
  localparam int P_STAB = 1;
  localparam int P_REL  = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         pll_locked;
  logic         pll_relock;
  logic [N-1:0] rst_out;
  logic         ready;
  logic [2:0]   state;
  logic [1:0]   loss_count;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .NUM_RST(N), .STABLE_CYCLES(SC), .STAGGER(S),
    .TIMEOUT_CYCLES(T), .RELOCK_PULSE(P), .CNT_W(2)
  ) dut (
    .clock_in   (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .pll_relock (pll_relock),
    .rst_out    (rst_out),
    .ready      (ready),
    .state      (state),
    .loss_count (loss_count)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] rst;
    logic       rdy;
    logic       rl;
    logic [1:0] lc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Model: phase plus elapsed cycles within it; lock history delays by two edges.
  int ph     = P_WAIT;
  int t      = 0;
  int losses = 0;
  bit hist[$];

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    if (ph == P_WAIT) begin
      e.st  = (t < T) ? 3'd0 : 3'd1;
      e.rl  = (t >= T);
      e.rst = '1;
    end else if (ph == P_STAB) begin
      e.st  = 3'd2;
      e.rst = '1;
    end else begin
      e.rdy = (t > LASTK);
      e.st  = e.rdy ? 3'd4 : 3'd3;
      for (int i = 0; i < N; i++) e.rst[i] = (t <= i * S);
    end
`ifdef PLL_RST_LOSS_CNT_EN
    e.lc = 2'((losses > LCMAX) ? LCMAX : losses);
`else
    e.lc = 2'd0;
`endif
    return e;
  endfunction

  task automatic model_edge(input bit r, input bit l);
    bit ls;
    if (r) begin
      ph = P_WAIT; t = 0; losses = 0;
      hist = {1'b0, 1'b0};
    end else begin
      ls = hist[0];
      void'(hist.pop_front());
      hist.push_back(l);
      if (ph == P_WAIT) begin
        if ((t < T) && ls) begin ph = P_STAB; t = 0; end
        else t = (t + 1) % PER;
      end else if (ph == P_STAB) begin
        if (!ls) begin ph = P_WAIT; t = 0; end
        else if (t == SC - 1) begin ph = P_REL; t = 0; end
        else t++;
      end else begin
        if (!ls) begin ph = P_WAIT; t = 0; losses++; end
        else if (t <= LASTK) t++;
      end
    end
  endtask

  task automatic drive(input bit r, input bit l);
    reset      = r;
    pll_locked = l;
    @(posedge clk);
    model_edge(r, l);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic hold(input bit l, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, l);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL cyc %0d %s got %0h exp %0h", cyc, nm, got, exp);
  endtask

  // Monitor: one expected record per clock, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        check("state",      32'(state),      32'(e.st));
        check("rst_out",    32'(rst_out),    32'(e.rst));
        check("ready",      32'(ready),      32'(e.rdy));
        check("pll_relock", 32'(pll_relock), 32'(e.rl));
        check("loss_count", 32'(loss_count), 32'(e.lc));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    reset = 1'b1;
    pll_locked = 1'b0;
    repeat (3) drive(1'b1, 1'b0);
    hold(1'b0, 10);
    hold(1'b1, 40);            // clean lock through release into run
    hold(1'b0, 80);            // timeouts and relock pulses
    hold(1'b1, 7); hold(1'b0, 1); hold(1'b1, 25);   // glitch in stable
    hold(1'b1, 0);
    hold(1'b0, 1); hold(1'b1, 10); hold(1'b0, 1);   // loss mid-release
    for (int i = 0; i < 6; i++) begin               // repeated run losses: saturation
      hold(1'b1, 25);
      hold(1'b0, 3);
    end
    hold(1'b1, 25);
    drive(1'b1, 1'b1);         // reset while running
    hold(1'b1, 25);
    for (int seg = 0; seg < 60; seg++) begin
      mode = int'($urandom_range(0, 9));
      if (mode <= 2) hold(1'b0, int'($urandom_range(5, 80)));
      else if (mode <= 6) hold(1'b1, int'($urandom_range(3, 40)));
      else if (mode <= 8) begin
        for (int k = 0; k < 12; k++) drive(1'b0, 1'($urandom_range(0, 1)));
      end else if (seg >= 30) drive(1'b1, 1'($urandom_range(0, 1)));
      else hold(1'b1, 5);
    end
    hold(1'b0, 3);
    @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
